// File: rtl/i_cache_assoc_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// The cache uses the slave view; the fetch stage and memory bus model use the master view.
interface i_cache_assoc_if #(
    parameter int A_WIDTH = 32
);
    logic [A_WIDTH-1:0] p_a;
    logic               p_strobe;
    logic               p_flush;
    logic [31:0]        p_din;
    logic               p_ready;
    logic               cache_miss;
    logic [A_WIDTH-1:0] m_a;
    logic               m_strobe;
    logic [31:0]        m_dout;
    logic               m_ready;

    modport master (
        output p_a, p_strobe, p_flush, m_dout, m_ready,
        input  p_din, p_ready, cache_miss, m_a, m_strobe
    );

    modport slave (
        input  p_a, p_strobe, p_flush, m_dout, m_ready,
        output p_din, p_ready, cache_miss, m_a, m_strobe
    );
endinterface

// File: rtl/i_cache_assoc.sv
// 2-way set-associative instruction cache with 1-bit LRU, word-sequential line refill,
// kseg1 uncached bypass and whole-cache flush.
module i_cache_assoc #(
    parameter int         A_WIDTH = 32,
    parameter int         C_INDEX = 6,
    parameter int         OFFSET  = 2,
    parameter logic [2:0] UNC_SEG = 3'b101
) (
    input logic            clk,
    input logic            rst,
    i_cache_assoc_if.slave bus
);
    localparam int T_WIDTH    = A_WIDTH - C_INDEX - OFFSET - 2;
    localparam int SETS       = 1 << C_INDEX;
    localparam int LINE_WORDS = 1 << OFFSET;

    typedef enum logic [1:0] {IDLE, REFILL, UNCACHED, FLUSH} state_t;
    state_t state;

    logic [31:0]        data_mem [2][SETS][LINE_WORDS];
    logic [T_WIDTH-1:0] tag_mem  [2][SETS];
    logic [SETS-1:0]    valid [2];
    logic [SETS-1:0]    lru;

    logic [A_WIDTH-1:0] req_a;
    logic               victim;
    logic [OFFSET-1:0]  cnt;
    logic               flush_pend;

    logic [T_WIDTH-1:0] p_tag;
    logic [C_INDEX-1:0] p_set;
    logic [OFFSET-1:0]  p_word;
    logic [T_WIDTH-1:0] r_tag;
    logic [C_INDEX-1:0] r_set;
    logic               hit0, hit1, hit, uncached, victim_sel, last_word, flush_now;
    logic               unused_bits;

    assign p_tag       = bus.p_a[A_WIDTH-1 -: T_WIDTH];
    assign p_set       = bus.p_a[C_INDEX+OFFSET+1:OFFSET+2];
    assign p_word      = bus.p_a[OFFSET+1:2];
    assign r_tag       = req_a[A_WIDTH-1 -: T_WIDTH];
    assign r_set       = req_a[C_INDEX+OFFSET+1:OFFSET+2];
    assign unused_bits = ^bus.p_a[1:0];

    assign uncached  = (bus.p_a[A_WIDTH-1 -: 3] == UNC_SEG);
    assign hit0      = valid[0][p_set] && (tag_mem[0][p_set] == p_tag);
    assign hit1      = valid[1][p_set] && (tag_mem[1][p_set] == p_tag);
    assign hit       = (state == IDLE) && bus.p_strobe && !uncached && (hit0 || hit1);
    assign last_word = bus.m_ready && (cnt == OFFSET'(LINE_WORDS - 1));
    assign flush_now = flush_pend || bus.p_flush;

    // Fill an empty way before evicting; way0 when both are empty.
    assign victim_sel = !valid[0][p_set] ? 1'b0 :
                        !valid[1][p_set] ? 1'b1 : lru[p_set];

    always_comb begin
        bus.p_ready = 1'b0;
        bus.p_din   = '0;
        if (hit) begin
            bus.p_ready = 1'b1;
            bus.p_din   = hit0 ? data_mem[0][p_set][p_word] : data_mem[1][p_set][p_word];
        end else if (state == UNCACHED) begin
            bus.p_ready = bus.m_ready;
            bus.p_din   = bus.m_dout;
        end
    end

    assign bus.cache_miss = bus.p_strobe && !bus.p_ready;
    assign bus.m_strobe   = (state == REFILL) || (state == UNCACHED);

    always_comb begin
        bus.m_a = '0;
        if (state == REFILL)
            bus.m_a = {3'b000, req_a[A_WIDTH-4:0]} + {{(A_WIDTH-OFFSET-2){1'b0}}, cnt, 2'b00};
        else if (state == UNCACHED)
            bus.m_a = {3'b000, req_a[A_WIDTH-4:0]};
    end

    // Line storage has no reset; only valid bits decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (!rst && state == REFILL && bus.m_ready) begin
            data_mem[victim][r_set][cnt] <= bus.m_dout;
            if (last_word)
                tag_mem[victim][r_set] <= r_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid[0]   <= '0;
            valid[1]   <= '0;
            lru        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            req_a      <= '0;
            victim     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.p_strobe) begin
                        if (uncached) begin
                            req_a      <= bus.p_a;
                            flush_pend <= bus.p_flush;
                            state      <= UNCACHED;
                        end else if (hit0 || hit1) begin
                            lru[p_set] <= hit0;
                            if (bus.p_flush)
                                state <= FLUSH;
                        end else begin
                            req_a      <= {bus.p_a[A_WIDTH-1:OFFSET+2], {(OFFSET+2){1'b0}}};
                            victim     <= victim_sel;
                            cnt        <= '0;
                            flush_pend <= bus.p_flush;
                            state      <= REFILL;
                        end
                    end else if (bus.p_flush) begin
                        state <= FLUSH;
                    end
                end
                REFILL: begin
                    if (bus.p_flush)
                        flush_pend <= 1'b1;
                    if (bus.m_ready)
                        cnt <= cnt + 1'b1;
                    // A flush seen at any point of the refill leaves the new line invalid.
                    if (last_word) begin
                        valid[victim][r_set] <= !flush_now;
                        lru[r_set]           <= ~victim;
                        state                <= flush_now ? FLUSH : IDLE;
                    end
                end
                UNCACHED: begin
                    if (bus.p_flush)
                        flush_pend <= 1'b1;
                    if (bus.m_ready)
                        state <= flush_now ? FLUSH : IDLE;
                end
                FLUSH: begin
                    valid[0]   <= '0;
                    valid[1]   <= '0;
                    lru        <= '0;
                    flush_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i_cache_assoc.sv
// Scoreboard bench for i_cache_assoc: memory model with variable latency, expected fetch
// data and expected memory addresses queued at stimulus time and compared on DUT output.
module tb_i_cache_assoc;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i_cache_assoc_if bus ();
    i_cache_assoc dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_ma[$];
    int          mem_tx = 0;
    int          max_delay = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory slave: random 0..max_delay wait per word, one-cycle m_ready pulse.
    initial begin : mem_model
        int          dly;
        logic        busy;
        logic [31:0] start_a;
        busy = 1'b0;
        dly = 0;
        start_a = '0;
        bus.m_ready = 1'b0;
        bus.m_dout = '0;
        forever begin
            @(negedge clk);
            if (bus.m_ready || rst || !bus.m_strobe) begin
                bus.m_ready = 1'b0;
                busy = 1'b0;
            end
            if (bus.m_strobe && !rst) begin
                if (!busy) begin
                    busy = 1'b1;
                    dly = $urandom_range(max_delay, 0);
                    start_a = bus.m_a;
                end
                if (dly == 0) begin
                    chk("ma_hold", bus.m_a, start_a);
                    chk("ma_queue", 32'(exp_ma.size() > 0), 32'd1);
                    if (exp_ma.size() > 0)
                        chk("m_a", bus.m_a, exp_ma.pop_front());
                    bus.m_dout = mem_word(bus.m_a);
                    bus.m_ready = 1'b1;
                    mem_tx++;
                end else begin
                    dly--;
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input int exp_tx, input string tag);
        int          cycles;
        int          base;
        bit          unc;
        logic [31:0] la;
        unc = (a[31:29] == 3'b101);
        la = {3'b000, a[28:0]};
        exp_q.push_back(mem_word(la));
        if (unc) begin
            exp_ma.push_back(la);
        end else begin
            for (int r = 0; r < exp_tx / 4; r++)
                for (int w = 0; w < 4; w++)
                    exp_ma.push_back({la[31:4], 4'h0} + 32'(w * 4));
        end
        @(negedge clk);
        base = mem_tx;
        bus.p_a = a;
        bus.p_strobe = 1'b1;
        #1;
        chk({tag, ".miss"}, 32'(bus.cache_miss), 32'(exp_tx > 0));
        cycles = 1;
        while (!bus.p_ready && cycles < 400) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        chk({tag, ".ready"}, 32'(bus.p_ready), 32'd1);
        if (bus.p_ready) begin
            chk({tag, ".p_din"}, bus.p_din, exp_q.pop_front());
        end else begin
            exp_q.delete();
            exp_ma.delete();
        end
        chk({tag, ".ntx"}, 32'(mem_tx - base), 32'(exp_tx));
        chk({tag, ".ma_left"}, 32'(exp_ma.size()), 32'd0);
        if (max_delay == 0)
            chk({tag, ".lat"}, 32'(cycles), (exp_tx == 0) ? 32'd1 : unc ? 32'd2 : 32'(exp_tx + 2));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int b;
        rst = 1'b1;
        bus.p_a = 32'h8000_0000;
        bus.p_strobe = 1'b1;
        bus.p_flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.p_ready", 32'(bus.p_ready), 32'd0);
        chk("rst.m_strobe", 32'(bus.m_strobe), 32'd0);
        chk("rst.cache_miss", 32'(bus.cache_miss), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.p_strobe = 1'b0;

        // Basic refill order and same-line hit
        max_delay = 0;
        fetch(32'h8000_0000, 4, "t1a");
        fetch(32'h8000_0008, 0, "t1b");

        // LRU replacement in set 0
        max_delay = 5;
        fetch(32'h8000_0400, 4, "t2b");
        fetch(32'h8000_0000, 0, "t2a");
        fetch(32'h8000_0800, 4, "t2c");
        fetch(32'h8000_0000, 0, "t2a2");
        fetch(32'h8000_0400, 4, "t2b2");
        fetch(32'h8000_0800, 4, "t2c2");
        fetch(32'h8000_0404, 0, "t2b3");

        // Uncached bypass, no allocation
        max_delay = 0;
        fetch(32'hA000_0010, 1, "t3a");
        fetch(32'hA000_0010, 1, "t3b");
        fetch(32'h8000_0010, 4, "t3c");

        // Flush raised in the middle of a refill: line completes, stays invalid, then refills
        max_delay = 3;
        fork
            begin
                b = mem_tx;
                for (int i = 0; i < 400 && mem_tx < b + 2; i++) begin
                    @(negedge clk);
                    #2;
                end
                bus.p_flush = 1'b1;
                @(negedge clk);
                #2;
                bus.p_flush = 1'b0;
            end
        join_none
        fetch(32'h8000_0200, 8, "t4y");
        fetch(32'h8000_0800, 4, "t4c");
        fetch(32'h8000_0010, 4, "t4d");
        @(negedge clk);
        bus.p_strobe = 1'b0;
        bus.p_flush = 1'b1;
        @(negedge clk);
        bus.p_flush = 1'b0;
        fetch(32'h8000_0010, 4, "t4e");

        // Reset in the middle of a refill
        max_delay = 5;
        for (int w = 0; w < 4; w++)
            exp_ma.push_back(32'h0000_0300 + 32'(w * 4));
        @(negedge clk);
        b = mem_tx;
        bus.p_a = 32'h8000_0300;
        bus.p_strobe = 1'b1;
        for (int i = 0; i < 400 && mem_tx < b + 1; i++) begin
            @(negedge clk);
            #2;
        end
        chk("t5.started", 32'(mem_tx - b), 32'd1);
        bus.p_strobe = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("t5.m_strobe", 32'(bus.m_strobe), 32'd0);
        rst = 1'b0;
        exp_ma.delete();
        fetch(32'h8000_0300, 4, "t5b");
        fetch(32'h8000_030C, 0, "t5c");

        @(negedge clk);
        bus.p_strobe = 1'b0;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
